nexys_starship_ssd_scan: RTL and testbench

Parametrised multiplexed seven-segment display driver for the Nexys starship design, replacing the fixed 8-digit scan/decode logic in the top level. It time-multiplexes N hex digits onto shared active-low cathodes, adds per-digit blanking, decimal points, blinking and PWM brightness, and double-buffers the displayed values so updates land only on a frame boundary (no tearing).

---
 rtl/nexys_starship_ssd_scan.sv | 148 ++++++++++++++
 tb/tb_nexys_starship_ssd_scan.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nexys_starship_ssd_scan.sv
// Multiplexed N-digit seven-segment scanner: shared active-low cathodes, per-digit
// blank/dp/blink, PWM brightness and frame-synchronous double-buffered values.

module nexys_starship_ssd_digit (
    input  logic [3:0] nibble,
    input  logic       shown,
    input  logic       dp,
    input  logic       hidden,
    input  logic       duty_on,
    output logic       lit,
    output logic [7:0] seg
);
    logic [6:0] abcdefg;

    always_comb begin
        abcdefg = 7'b1111111;
        case (nibble)
            4'h0:    abcdefg = 7'b0000001;
            4'h1:    abcdefg = 7'b1001111;
            4'h2:    abcdefg = 7'b0010010;
            4'h3:    abcdefg = 7'b0000110;
            4'h4:    abcdefg = 7'b1001100;
            4'h5:    abcdefg = 7'b0100100;
            4'h6:    abcdefg = 7'b0100000;
            4'h7:    abcdefg = 7'b0001111;
            4'h8:    abcdefg = 7'b0000000;
            4'h9:    abcdefg = 7'b0000100;
            4'hA:    abcdefg = 7'b0001000;
            4'hB:    abcdefg = 7'b1100000;
            4'hC:    abcdefg = 7'b0110001;
            4'hD:    abcdefg = 7'b1000010;
            4'hE:    abcdefg = 7'b0110000;
            4'hF:    abcdefg = 7'b0111000;
            default: abcdefg = 7'b1111111;
        endcase
    end

    assign seg = {abcdefg, ~dp};
    assign lit = shown & ~hidden & duty_on;
endmodule

module nexys_starship_ssd_scan #(
    parameter int N_DIGITS   = 8,
    parameter int PRESCALE_W = 14,
    parameter int BLINK_W    = 26
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [4*N_DIGITS-1:0] digit_data,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic [N_DIGITS-1:0]   dp_en,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic [3:0]            brightness,
    input  logic                  load,
    output logic                  upd_pending,
    output logic                  frame_start,
    output logic [N_DIGITS-1:0]   anodes_n,
    output logic [7:0]            cathodes_n
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    typedef struct packed {
        logic [N_DIGITS-1:0][3:0] data;
        logic [N_DIGITS-1:0]      en;
        logic [N_DIGITS-1:0]      dp;
        logic [N_DIGITS-1:0]      blink;
        logic [3:0]               bright;
    } disp_set_t;

    logic [PRESCALE_W-1:0]      prescale;
    logic [IDX_W-1:0]           digit_idx;
    logic [BLINK_W-1:0]         blink_cnt;
    disp_set_t                  in_set, stg_set, act_set;
    logic                       frame_end, blink_off, duty_on;
    logic [N_DIGITS-1:0]        digit_lit;
    logic [N_DIGITS-1:0][7:0]   digit_seg;

    assign in_set = '{data: digit_data, en: digit_en, dp: dp_en,
                      blink: blink_mask, bright: brightness};

    assign frame_end = (&prescale) && (digit_idx == LAST_IDX);
    assign blink_off = blink_cnt[BLINK_W-1];
    assign duty_on   = prescale[PRESCALE_W-1 -: 4] <= act_set.bright;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            prescale  <= '0;
            digit_idx <= '0;
            blink_cnt <= '0;
        end else begin
            prescale  <= prescale + 1'b1;
            blink_cnt <= blink_cnt + 1'b1;
            if (&prescale)
                digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
        end
    end

    // A load landing on the boundary cycle goes straight to the active set,
    // otherwise staged values wait for the next boundary so a frame never tears.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stg_set     <= '0;
            act_set     <= '0;
            upd_pending <= 1'b0;
        end else if (load && frame_end) begin
            act_set     <= in_set;
            upd_pending <= 1'b0;
        end else if (load) begin
            stg_set     <= in_set;
            upd_pending <= 1'b1;
        end else if (frame_end && upd_pending) begin
            act_set     <= stg_set;
            upd_pending <= 1'b0;
        end
    end

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
        nexys_starship_ssd_digit u_digit (
            .nibble  (act_set.data[g]),
            .shown   (act_set.en[g]),
            .dp      (act_set.dp[g]),
            .hidden  (blink_off & act_set.blink[g]),
            .duty_on (duty_on),
            .lit     (digit_lit[g]),
            .seg     (digit_seg[g])
        );
    end

    // Prescaler zero is the first cycle of a slot; keeping it dark hides the
    // anode/cathode switchover and stops the previous digit ghosting.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            anodes_n    <= '1;
            cathodes_n  <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_end;
            if ((prescale != '0) && digit_lit[digit_idx]) begin
                anodes_n   <= ~(N_DIGITS'(1) << digit_idx);
                cathodes_n <= digit_seg[digit_idx];
            end else begin
                anodes_n   <= '1;
                cathodes_n <= 8'hFF;
            end
        end
    end
endmodule

// File: tb/tb_nexys_starship_ssd_scan.sv
// Bench for nexys_starship_ssd_scan: time-indexed display model checked every
// cycle, directed scenarios with literal expectations, then random loads.

module tb_nexys_starship_ssd_scan;
    localparam int ND = 4, PW = 6, BW = 10;
    localparam int SLOT = 1 << PW, FRAME = ND * SLOT, BLINK = 1 << BW;

    logic              Clk = 1'b0, Reset = 1'b0, load = 1'b0;
    logic [4*ND-1:0]   digit_data = '0;
    logic [ND-1:0]     digit_en = '0, dp_en = '0, blink_mask = '0;
    logic [3:0]        brightness = '0;
    logic              upd_pending, frame_start;
    logic [ND-1:0]     anodes_n;
    logic [7:0]        cathodes_n;

    int tests = 0, fails = 0;

    always #5 Clk = ~Clk;

    nexys_starship_ssd_scan #(.N_DIGITS(ND), .PRESCALE_W(PW), .BLINK_W(BW)) dut (
        .Clk(Clk), .Reset(Reset), .digit_data(digit_data), .digit_en(digit_en),
        .dp_en(dp_en), .blink_mask(blink_mask), .brightness(brightness), .load(load),
        .upd_pending(upd_pending), .frame_start(frame_start),
        .anodes_n(anodes_n), .cathodes_n(cathodes_n)
    );

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  en, dp, blk, br;
    } set_t;

    logic [6:0] seg_lut [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Model: n counts clock edges since reset release; slot, digit and blink
    // phase all follow from n by plain division.
    set_t        act, stg;
    bit          pend;
    int unsigned n;
    logic [3:0]  exp_an;
    logic [7:0]  exp_ca;
    bit          exp_fs;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic void expect_out(input set_t a, input int unsigned t,
                                       output logic [3:0] an, output logic [7:0] ca);
        int  p = int'(t % SLOT);
        int  i = int'((t / SLOT) % ND);
        bit  off = (t % BLINK) >= (BLINK / 2);
        an = '1;
        ca = 8'hFF;
        if (p != 0 && a.en[i] && !(off && a.blk[i]) && (p / (SLOT / 16)) <= int'(a.br)) begin
            an = ~(4'b0001 << i);
            ca = {seg_lut[a.data[4*i +: 4]], ~a.dp[i]};
        end
    endfunction

    always @(posedge Clk) begin
        if (!Reset) begin
            n = 0; act = '0; stg = '0; pend = 0;
            exp_an = '1; exp_ca = 8'hFF; exp_fs = 0;
        end else begin
            expect_out(act, n, exp_an, exp_ca);
            exp_fs = (n % FRAME) == FRAME - 1;
            if (load) begin
                if (exp_fs) begin
                    act = '{digit_data, digit_en, dp_en, blink_mask, brightness}; pend = 0;
                end else begin
                    stg = '{digit_data, digit_en, dp_en, blink_mask, brightness}; pend = 1;
                end
            end else if (exp_fs && pend) begin
                act = stg; pend = 0;
            end
            n++;
        end
        #1;
        chk("anodes", anodes_n, exp_an);
        chk("cathodes", cathodes_n, exp_ca);
        chk("upd_pending", upd_pending, pend);
        chk("frame_start", frame_start, exp_fs);
        chk("one_anode", $countones(~anodes_n) <= 1, 1);
    end

    task automatic do_load(input logic [15:0] d, input logic [3:0] en, dp, blk, br);
        digit_data = d; digit_en = en; dp_en = dp; blink_mask = blk; brightness = br;
        load = 1'b1;
        @(negedge Clk);
        load = 1'b0;
    endtask

    task automatic wait_phase(input int k);
        int b = 0;
        while (int'(n % FRAME) != k && b < 2 * FRAME) begin
            @(negedge Clk);
            b++;
        end
        chk("phase_timeout", b < 2 * FRAME, 1);
    endtask

    task automatic wait_fs();
        int b = 0;
        do begin
            @(posedge Clk); #1; b++;
        end while (!frame_start && b < 2 * FRAME + 10);
        chk("frame_start_timeout", frame_start, 1);
    endtask

    task automatic count_low(input int cycles, input int d, output int c);
        c = 0;
        repeat (cycles) begin
            @(posedge Clk); #1;
            if (!anodes_n[d]) c++;
        end
    endtask

    initial begin
        int c, period;
        repeat (3) @(negedge Clk);
        chk("rst_anodes", anodes_n, 4'hF);
        chk("rst_cathodes", cathodes_n, 8'hFF);
        chk("rst_upd", upd_pending, 0);
        Reset = 1'b1;

        c = 0;
        repeat (1000) begin
            @(posedge Clk); #1;
            if (anodes_n !== 4'hF || cathodes_n !== 8'hFF || upd_pending !== 1'b0) c++;
        end
        chk("idle_dark", c, 0);

        @(negedge Clk);
        wait_phase(100);
        do_load(16'hA321, 4'hF, 4'b0010, 4'h0, 4'd15);
        chk("upd_after_load", upd_pending, 1);
        wait_fs();
        chk("upd_cleared", upd_pending, 0);
        @(posedge Clk); #1;
        chk("guard_cycle", anodes_n, 4'hF);
        @(posedge Clk); #1;
        chk("d0_anode", anodes_n, 4'b1110);
        chk("d0_cath", cathodes_n, 8'b10011111);
        repeat (SLOT) @(posedge Clk); #1;
        chk("d1_cath", cathodes_n, 8'b00100100);
        repeat (2 * SLOT) @(posedge Clk); #1;
        chk("d3_anode", anodes_n, 4'b0111);
        chk("d3_cath", cathodes_n, 8'b00010001);

        wait_fs();
        count_low(FRAME, 0, c);
        chk("d0_lit_cycles", c, SLOT - 1);
        period = 0;
        do begin
            @(posedge Clk); #1; period++;
        end while (!frame_start && period < 2 * FRAME);
        chk("frame_period", period, FRAME);

        @(negedge Clk);
        wait_phase(100);
        do_load(16'hA321, 4'hF, 4'b0010, 4'h0, 4'd3);
        wait_fs();
        count_low(FRAME, 1, c);
        chk("dim_lit_cycles", c, 15);

        @(negedge Clk);
        wait_phase(100);
        do_load(16'hA321, 4'hF, 4'b0000, 4'b0100, 4'd15);
        wait_fs();
        c = 0;
        period = 0;
        repeat (BLINK) begin
            @(posedge Clk); #1;
            if (!anodes_n[2]) c++;
            if (!anodes_n[0]) period++;
        end
        chk("blink_d2_cycles", c, 2 * (SLOT - 1));
        chk("blink_d0_cycles", period, 4 * (SLOT - 1));

        @(negedge Clk);
        wait_phase(50);
        do_load(16'h1111, 4'hF, 4'h0, 4'h0, 4'd15);
        wait_phase(120);
        do_load(16'h2222, 4'hF, 4'h0, 4'h0, 4'd15);
        chk("upd_two_loads", upd_pending, 1);
        wait_fs();
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        chk("last_load_wins", cathodes_n, 8'b00100101);
        @(negedge Clk);
        wait_phase(FRAME - 1);
        do_load(16'h3333, 4'hF, 4'h0, 4'h0, 4'd15);
        chk("bypass_upd", upd_pending, 0);
        chk("bypass_fs", frame_start, 1);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        chk("bypass_cath", cathodes_n, 8'b00001101);

        @(negedge Clk);
        wait_phase(30);
        do_load(16'h5555, 4'hF, 4'hF, 4'h0, 4'd15);
        chk("upd_before_rst", upd_pending, 1);
        repeat (10) @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("midrst_anodes", anodes_n, 4'hF);
        chk("midrst_cath", cathodes_n, 8'hFF);
        chk("midrst_upd", upd_pending, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        c = 0;
        repeat (2 * FRAME + 50) begin
            @(posedge Clk); #1;
            if (anodes_n !== 4'hF) c++;
        end
        chk("staged_discarded", c, 0);

        @(negedge Clk);
        repeat (6000) begin
            if ($urandom_range(0, 39) == 0 ||
                (int'(n % FRAME) == FRAME - 1 && $urandom_range(0, 2) == 0)) begin
                digit_data = 16'($urandom);
                digit_en   = 4'($urandom);
                dp_en      = 4'($urandom);
                blink_mask = 4'($urandom);
                brightness = 4'($urandom);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge Clk);
        end
        load = 1'b0;
        repeat (5) @(negedge Clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
